// File: rtl/connect4_board_engine.sv
// +--------------------------------------------------------------------------+
// | Module   : connect4_board_engine                                         |
// | Purpose  : Connect-4 board with gravity drops, player alternation and a  |
// |            one-cell-per-cycle win/draw scan. Optional macro             |
// |            BOARD_CLEAR_EN adds a synchronous 'clear' input.              |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module connect4_board_engine #(
    parameter int COLS    = 4,
    parameter int ROWS    = 4,
    parameter int WIN_LEN = 4,
    parameter int CW      = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef BOARD_CLEAR_EN
    input  logic                     clear,
`endif
    input  logic                     move_valid,
    input  logic [CW-1:0]            move_col,
    output logic                     move_ready,
    output logic                     move_accept,
    output logic                     move_reject,
    output logic [ROWS*COLS-1:0]     cell_occ,
    output logic [ROWS*COLS-1:0]     cell_owner,
    output logic [2*ROWS*COLS-1:0]   led_bus,
    output logic                     player,
    output logic [1:0]               game_status,
    output logic                     busy
);

    localparam int N  = ROWS * COLS;
    localparam int HW = $clog2(ROWS + 1);
    localparam int MW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [MW-1:0]   moves_q, moves_d;
    logic            player_q, player_d;
    logic [1:0]      status_q, status_d;
    logic            accept_q, accept_d;
    logic            reject_q, reject_d;
    logic [N-1:0]    occ_q, occ_d;
    logic [N-1:0]    owner_q, owner_d;
    logic [2*N-1:0]  led_q, led_d;
    logic [HW-1:0]   height_q [COLS];
    logic [HW-1:0]   height_d [COLS];

    logic            clear_req;
    logic            handshake;
    logic            col_ok;
    logic            legal;
    logic [HW-1:0]   height;
    logic [COLS-1:0] col_hit;
    logic [N-1:0]    drop;
    logic [N-1:0]    mine;
    logic [N-1:0]    cell_win;

`ifdef BOARD_CLEAR_EN
    assign clear_req = clear;
`else
    assign clear_req = 1'b0;
`endif

    // A clear in the same cycle as a handshake swallows it entirely.
    assign handshake = move_valid && (state_q == ST_IDLE) && !clear_req;
    assign col_ok    = ({1'b0, move_col} < (CW + 1)'(COLS));
    assign legal     = handshake && col_ok && (height != HW'(ROWS));
    assign mine      = occ_q & (player_q ? owner_q : ~owner_q);

    always_comb begin
        height = '0;
        for (int c = 0; c < COLS; c++) begin
            if (col_hit[c]) height = height_q[c];
        end
    end

    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
        assign col_hit[gc]  = (move_col == CW'(gc));
        assign height_d[gc] = clear_req ? '0 :
                              (legal && col_hit[gc]) ? height_q[gc] + HW'(1) : height_q[gc];
    end

    // Each cell precomputes whether a WIN_LEN run of the mover starts there in
    // any forward direction; runs that would leave the board are tied off.
    for (genvar gi = 0; gi < N; gi++) begin : g_cell
        localparam int C = gi / ROWS;
        localparam int R = gi % ROWS;
        logic [3:0] dir_hit;
        for (genvar gd = 0; gd < 4; gd++) begin : g_dir
            localparam int DC    = (gd == 0) ? 0 : 1;
            localparam int DR    = (gd == 1) ? 0 : ((gd == 3) ? -1 : 1);
            localparam int END_C = C + DC * (WIN_LEN - 1);
            localparam int END_R = R + DR * (WIN_LEN - 1);
            if (END_C < COLS && END_R >= 0 && END_R < ROWS) begin : g_fit
                logic [WIN_LEN-1:0] seg;
                for (genvar gk = 0; gk < WIN_LEN; gk++) begin : g_k
                    assign seg[gk] = mine[(C + DC * gk) * ROWS + R + DR * gk];
                end
                assign dir_hit[gd] = &seg;
            end else begin : g_nofit
                assign dir_hit[gd] = 1'b0;
            end
        end
        assign cell_win[gi]     = |dir_hit;
        assign drop[gi]         = legal && col_hit[C] && (height == HW'(R));
        assign led_d[2*gi]      = !clear_req && occ_q[gi] && !owner_q[gi];
        assign led_d[2*gi+1]    = !clear_req && occ_q[gi] &&  owner_q[gi];
    end

    assign occ_d    = clear_req ? '0 : (occ_q | drop);
    assign owner_d  = clear_req ? '0 :
                      (player_q ? (owner_q | drop) : (owner_q & ~drop));
    assign accept_d = legal;
    assign reject_d = handshake && !legal;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        moves_d  = moves_q;
        player_d = player_q;
        status_d = status_q;
        case (state_q)
            ST_IDLE: begin
                if (legal) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    moves_d = moves_q + MW'(1);
                end
            end
            ST_SCAN: begin
                if (cell_win[idx_q]) begin
                    status_d = player_q ? 2'b10 : 2'b01;
                    state_d  = ST_DONE;
                end else if (idx_q == IW'(N - 1)) begin
                    if (moves_q == MW'(N)) begin
                        status_d = 2'b11;
                        state_d  = ST_DONE;
                    end else begin
                        player_d = !player_q;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: ;
        endcase
        if (clear_req) begin
            state_d  = ST_IDLE;
            idx_d    = '0;
            moves_d  = '0;
            player_d = 1'b0;
            status_d = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            moves_q  <= '0;
            player_q <= 1'b0;
            status_q <= 2'b00;
            accept_q <= 1'b0;
            reject_q <= 1'b0;
            occ_q    <= '0;
            owner_q  <= '0;
            led_q    <= '0;
            for (int c = 0; c < COLS; c++) height_q[c] <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            moves_q  <= moves_d;
            player_q <= player_d;
            status_q <= status_d;
            accept_q <= accept_d;
            reject_q <= reject_d;
            occ_q    <= occ_d;
            owner_q  <= owner_d;
            led_q    <= led_d;
            for (int c = 0; c < COLS; c++) height_q[c] <= height_d[c];
        end
    end

    assign move_ready  = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_SCAN);
    assign move_accept = accept_q;
    assign move_reject = reject_q;
    assign cell_occ    = occ_q;
    assign cell_owner  = owner_q;
    assign led_bus     = led_q;
    assign player      = player_q;
    assign game_status = status_q;

endmodule

`default_nettype wire
